// File: rtl/shift_reg_pkg.sv
// Mode encodings and helpers shared by the universal shift register and its future
// parallel-in/serial-out controller.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) ||
           (mode == MODE_ROTR) || (mode == MODE_ROTL);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Counts shifts within a WIDTH-long frame; done pulses for one cycle after the wrapping shift.
// Latency: cnt and done are registered, one cycle after the inc/clr edge.
module frame_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // done is reloaded every edge so it can never stretch past one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: bidirectional shift, rotate, parallel load, clear, frame counting.
// Latency: all outputs are register taps, updated one cycle after the enabled edge.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             s_in_r,
  input  logic             s_in_l,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] p_out,
  output logic             s_out_r,
  output logic             s_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  if (WIDTH < 2) begin : g_width_check
    $error("univ_shift_reg: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             cnt_inc, cnt_clr;

  always_comb begin
    sr_d = sr_q;
    if (en) begin
      case (mode)
        MODE_SHR:  sr_d = {s_in_r, sr_q[WIDTH-1:1]};
        MODE_SHL:  sr_d = {sr_q[WIDTH-2:0], s_in_l};
        MODE_LOAD: sr_d = p_in;
        MODE_ROTR: sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
        MODE_ROTL: sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        MODE_CLR:  sr_d = '0;
        default:   sr_d = sr_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign cnt_inc = en && is_shift(mode);
  assign cnt_clr = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));

  frame_counter #(.WIDTH(WIDTH)) u_frame_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (shift_cnt),
    .done (frame_done)
  );

  assign p_out   = sr_q;
  assign s_out_r = sr_q[0];
  assign s_out_l = sr_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus a random soak,
// with expected state queued at drive time and compared after each clock edge.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, en, s_in_r, s_in_l;
  logic [2:0]    mode;
  logic [W-1:0]  p_in, p_out;
  logic          s_out_r, s_out_l, frame_done;
  logic [CW-1:0] shift_cnt;

  typedef struct packed {
    logic [W-1:0]  p;
    logic [CW-1:0] c;
    logic          d;
  } exp_t;

  exp_t sbq[$];
  exp_t exp;
  logic [W-1:0]  m_sr;
  logic [CW-1:0] m_cnt;
  logic          m_done;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s_in_r(s_in_r), .s_in_l(s_in_l),
    .p_in(p_in), .p_out(p_out), .s_out_r(s_out_r), .s_out_l(s_out_l),
    .shift_cnt(shift_cnt), .frame_done(frame_done)
  );

  // Drive one cycle of stimulus, advance the reference model and queue its expectation.
  task automatic apply(input logic e, input logic [2:0] m, input logic r, input logic l,
                       input logic [W-1:0] pi);
    logic shift;
    en = e; mode = m; s_in_r = r; s_in_l = l; p_in = pi;
    shift  = e && (m == 3'b001 || m == 3'b010 || m == 3'b100 || m == 3'b101);
    m_done = shift && (m_cnt == CW'(W - 1));
    if (e) begin
      case (m)
        3'b001: m_sr = {r, m_sr[W-1:1]};
        3'b010: m_sr = {m_sr[W-2:0], l};
        3'b011: m_sr = pi;
        3'b100: m_sr = {m_sr[0], m_sr[W-1:1]};
        3'b101: m_sr = {m_sr[W-2:0], m_sr[W-1]};
        3'b110: m_sr = '0;
        default: ;
      endcase
      if (m == 3'b011 || m == 3'b110) m_cnt = '0;
      else if (shift) m_cnt = m_done ? '0 : m_cnt + 1'b1;
    end
    sbq.push_back('{p: m_sr, c: m_cnt, d: m_done});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 3'b000; s_in_r = 1'b0; s_in_l = 1'b0; p_in = '0;
    #12;
    vectors++;
    if ({p_out, shift_cnt, frame_done} !== {8'h00, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_initial: p_out=%h cnt=%0d done=%b want 00/0/0", p_out, shift_cnt, frame_done);
    end
    @(negedge clk); rst = 1'b0;
    m_sr = '0; m_cnt = '0; m_done = 1'b0;
    @(posedge clk); #1;
    apply(1, 3'b011, 0, 0, 8'h5C);
    for (int i = 0; i < 3; i++) apply(1, 3'b001, 1, 0, 8'h00);
    while (sbq.size() > 0) begin
      exp = sbq.pop_front();
      vectors++;
      if ({p_out, shift_cnt} !== {exp.p, exp.c} && sbq.size() == 0) begin
        miscompares++;
        $display("FAIL reset_preframe: p_out=%h cnt=%0d want %h/%0d", p_out, shift_cnt, exp.p, exp.c);
      end
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({p_out, shift_cnt, frame_done} !== {8'h00, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async_midframe: p_out=%h cnt=%0d done=%b want 00/0/0", p_out, shift_cnt, frame_done);
    end
    @(negedge clk); rst = 1'b0;
    m_sr = '0; m_cnt = '0; m_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_shr();
    logic [W-1:0] pat = 8'hA5;
    apply(1, 3'b011, 0, 0, pat);
    exp = sbq.pop_front(); vectors++;
    if ({p_out, shift_cnt, frame_done} !== exp) begin
      miscompares++;
      $display("FAIL load: p_out=%h cnt=%0d done=%b want %h/%0d/%b", p_out, shift_cnt, frame_done, exp.p, exp.c, exp.d);
    end
    for (int i = 0; i < W; i++) begin
      vectors++;
      if (s_out_r !== pat[i]) begin
        miscompares++;
        $display("FAIL shr_serial_out[%0d]: s_out_r=%b want %b", i, s_out_r, pat[i]);
      end
      apply(1, 3'b001, 0, 0, 8'h00);
      exp = sbq.pop_front(); vectors++;
      if ({p_out, shift_cnt, frame_done} !== exp) begin
        miscompares++;
        $display("FAIL shr_step[%0d]: p_out=%h cnt=%0d done=%b want %h/%0d/%b", i, p_out, shift_cnt, frame_done, exp.p, exp.c, exp.d);
      end
    end
    vectors++;
    if ({p_out, frame_done} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL shr_frame_end: p_out=%h done=%b want 00/1", p_out, frame_done);
    end
  endtask

  task automatic test_rotate_hold();
    apply(1, 3'b011, 0, 0, 8'h81);
    apply(1, 3'b101, 0, 0, 8'h00);
    apply(1, 3'b100, 0, 0, 8'h00);
    apply(1, 3'b100, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) apply(0, 3'b001, 1, 1, 8'hFF);
    while (sbq.size() > 0) begin
      exp = sbq.pop_front();
    end
    vectors++;
    if ({p_out, shift_cnt, frame_done} !== {8'hC0, 4'd3, 1'b0} || exp !== {8'hC0, 4'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL rotate_hold: p_out=%h cnt=%0d done=%b want C0/3/0", p_out, shift_cnt, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] stream = 8'hD2;
    int first_pulse = -1;
    int second_pulse = -1;
    apply(1, 3'b110, 0, 0, 8'h00);
    void'(sbq.pop_front());
    for (int i = 0; i < 2 * W; i++) begin
      apply(1, 3'b010, 0, (i < W) ? stream[W-1-i] : 1'b0, 8'h00);
      exp = sbq.pop_front(); vectors++;
      if ({p_out, shift_cnt, frame_done} !== exp) begin
        miscompares++;
        $display("FAIL shl_step[%0d]: p_out=%h cnt=%0d done=%b want %h/%0d/%b", i, p_out, shift_cnt, frame_done, exp.p, exp.c, exp.d);
      end
      if (frame_done === 1'b1) begin
        if (first_pulse < 0) first_pulse = cyc; else second_pulse = cyc;
      end
      if (i == W - 1) begin
        vectors++;
        if ({p_out, frame_done} !== {8'hD2, 1'b1}) begin
          miscompares++;
          $display("FAIL shl_stream: p_out=%h done=%b want D2/1", p_out, frame_done);
        end
      end
    end
    vectors++;
    if (first_pulse < 0 || second_pulse - first_pulse !== W) begin
      miscompares++;
      $display("FAIL frame_spacing: got %0d cycles want %0d", second_pulse - first_pulse, W);
    end
  endtask

  task automatic test_clr_reserved();
    apply(1, 3'b011, 0, 0, 8'h3C);
    for (int i = 0; i < 5; i++) apply(1, (i % 2) ? 3'b010 : 3'b001, 1, 1, 8'h00);
    apply(1, 3'b110, 0, 0, 8'hFF);
    while (sbq.size() > 0) exp = sbq.pop_front();
    vectors++;
    if ({p_out, shift_cnt, frame_done} !== {8'h00, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL clr: p_out=%h cnt=%0d done=%b want 00/0/0", p_out, shift_cnt, frame_done);
    end
    apply(1, 3'b011, 0, 0, 8'h6B);
    apply(1, 3'b001, 1, 0, 8'h00);
    apply(1, 3'b111, 1, 1, 8'hFF);
    apply(1, 3'b000, 1, 1, 8'hFF);
    while (sbq.size() > 0) exp = sbq.pop_front();
    vectors++;
    if ({p_out, shift_cnt, frame_done} !== {8'hB5, 4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL reserved_hold: p_out=%h cnt=%0d done=%b want B5/1/0", p_out, shift_cnt, frame_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      apply(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 8'($urandom));
      exp = sbq.pop_front(); vectors++;
      if ({p_out, shift_cnt, frame_done, s_out_l, s_out_r} !== {exp, exp.p[W-1], exp.p[0]}) begin
        miscompares++;
        $display("FAIL random[%0d]: p_out=%h cnt=%0d done=%b sl=%b sr=%b want %h/%0d/%b", i, p_out, shift_cnt, frame_done, s_out_l, s_out_r, exp.p, exp.c, exp.d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_shr();
    test_rotate_hold();
    test_back_to_back();
    test_clr_reserved();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
